// File: rtl/circuit1_sched_ctrl_if.sv
// Request/result bundle for circuit1_sched_ctrl.
// Handshake: start is taken only on an edge where busy=0; done is a one-cycle strobe, z/x hold until the next run rewrites them.
interface circuit1_sched_ctrl_if #(
    parameter int DATAWIDTH = 8
);
    logic                   start;
    logic [DATAWIDTH-1:0]   a;
    logic [DATAWIDTH-1:0]   b;
    logic [DATAWIDTH-1:0]   c;
    logic                   busy;
    logic                   done;
    logic [DATAWIDTH-1:0]   z;
    logic [2*DATAWIDTH-1:0] x;
    logic [2:0]             dbg_state;

    modport master (
        output start, a, b, c,
        input  busy, done, z, x, dbg_state
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, z, x, dbg_state
    );
endinterface

// File: rtl/circuit1_sched_ctrl.sv
// Multi-cycle scheduler: z = max(a+b, a+c), x = a*c - (a+b), using one shared
// add/sub unit and one multiplier, sequenced by a six-state FSM.
module circuit1_sched_ctrl #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    circuit1_sched_ctrl_if.slave sif
);
    localparam int XW = 2 * DATAWIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADD_D   = 3'd1,
        ADD_E   = 3'd2,
        CMP_MUL = 3'd3,
        SUB     = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t               state_q;
    logic [DATAWIDTH-1:0] a_q, b_q, c_q, d_q, e_q, z_q;
    logic [XW-1:0]        f_q, x_q;
    logic                 busy_q, done_q;

    logic [XW-1:0]        alu_a, alu_b, alu_y, mul_y;
    logic                 alu_sub;

    // Operand steering for the single shared adder/subtractor.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sub = 1'b0;
        case (state_q)
            ADD_D: begin
                alu_a = {{DATAWIDTH{1'b0}}, a_q};
                alu_b = {{DATAWIDTH{1'b0}}, b_q};
            end
            ADD_E: begin
                alu_a = {{DATAWIDTH{1'b0}}, a_q};
                alu_b = {{DATAWIDTH{1'b0}}, c_q};
            end
            SUB: begin
                alu_a   = f_q;
                alu_b   = {{DATAWIDTH{1'b0}}, d_q};
                alu_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_y = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    assign mul_y = {{DATAWIDTH{1'b0}}, a_q} * {{DATAWIDTH{1'b0}}, c_q};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            z_q     <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.start) begin
                        a_q     <= sif.a;
                        b_q     <= sif.b;
                        c_q     <= sif.c;
                        busy_q  <= 1'b1;
                        state_q <= ADD_D;
                    end
                end
                ADD_D: begin
                    d_q     <= alu_y[DATAWIDTH-1:0];
                    state_q <= ADD_E;
                end
                ADD_E: begin
                    e_q     <= alu_y[DATAWIDTH-1:0];
                    state_q <= CMP_MUL;
                end
                CMP_MUL: begin
                    // Ties pick e.
                    z_q     <= (d_q > e_q) ? d_q : e_q;
                    f_q     <= mul_y;
                    state_q <= SUB;
                end
                SUB: begin
                    x_q     <= alu_y;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sif.busy      = busy_q;
    assign sif.done      = done_q;
    assign sif.z         = z_q;
    assign sif.x         = x_q;
    assign sif.dbg_state = state_q;
endmodule

// File: tb/tb_circuit1_sched_ctrl.sv
// Bench for circuit1_sched_ctrl: fixed vectors, random operands against an
// arithmetic model, overlapping start requests and reset during a run.
module tb_circuit1_sched_ctrl;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [DW-1:0]   c;
        logic [DW-1:0]   z;
        logic [2*DW-1:0] x;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_done = 0;
    logic [3*DW-1:0] exp_q[$];
    vec_t tbl[4];

    always #5 Clk = ~Clk;

    circuit1_sched_ctrl_if #(.DATAWIDTH(DW)) sif ();
    circuit1_sched_ctrl #(.DATAWIDTH(DW)) dut (.Clk(Clk), .Rst(Rst), .sif(sif));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected {z, x} straight from the arithmetic definition.
    function automatic logic [3*DW-1:0] model(input int a, input int b, input int c);
        int d, e, zi, xi;
        logic [DW-1:0]   zz;
        logic [2*DW-1:0] xx;
        d  = (a + b) % (1 << DW);
        e  = (a + c) % (1 << DW);
        zi = (d > e) ? d : e;
        xi = a * c - d;
        if (xi < 0) xi = xi + (1 << (2 * DW));
        zz = zi[DW-1:0];
        xx = xi[2*DW-1:0];
        return {zz, xx};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] ez,
                          input logic [2*DW-1:0] ex, input string tag);
        int lat;
        sif.start = 1'b1;
        sif.a = a;
        sif.b = b;
        sif.c = c;
        tick();
        sif.start = 1'b0;
        sif.a = DW'($urandom_range(0, 255));
        sif.b = DW'($urandom_range(0, 255));
        sif.c = DW'($urandom_range(0, 255));
        check({tag, " busy"}, 32'(sif.busy), 32'd1);
        lat = 1;
        while (!sif.done && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " z"}, 32'(sif.z), 32'(ez));
        check({tag, " x"}, 32'(sif.x), 32'(ex));
        tick();
        check({tag, " done pulse"}, 32'(sif.done), 32'd0);
        check({tag, " idle busy"}, 32'(sif.busy), 32'd0);
        check({tag, " z hold"}, 32'(sif.z), 32'(ez));
    endtask

    task automatic score_done();
        logic [3*DW-1:0] e;
        if (sif.done) begin
            n_done++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("overlap z", 32'(sif.z), 32'(e[3*DW-1:2*DW]));
                check("overlap x", 32'(sif.x), 32'(e[2*DW-1:0]));
            end else begin
                check("overlap spurious done", 32'd1, 32'd0);
            end
        end
    endtask

    initial begin
        logic [3*DW-1:0] e;
        logic [DW-1:0] ra, rb, rc;
        int seen;

        tbl[0] = '{a: 8'd3,   b: 8'd4,   c: 8'd5,   z: 8'd8,   x: 16'd8};
        tbl[1] = '{a: 8'd200, b: 8'd100, c: 8'd10,  z: 8'd210, x: 16'd1956};
        tbl[2] = '{a: 8'd0,   b: 8'd5,   c: 8'd0,   z: 8'd5,   x: 16'd65531};
        tbl[3] = '{a: 8'd255, b: 8'd1,   c: 8'd255, z: 8'd254, x: 16'd65025};

        Rst = 1'b0;
        sif.start = 1'b0;
        sif.a = '0;
        sif.b = '0;
        sif.c = '0;
        #3;
        check("reset busy", 32'(sif.busy), 32'd0);
        check("reset done", 32'(sif.done), 32'd0);
        check("reset z", 32'(sif.z), 32'd0);
        check("reset x", 32'(sif.x), 32'd0);
        tick();
        tick();
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].z, tbl[i].x, $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ra = DW'($urandom_range(0, 255));
            rb = DW'($urandom_range(0, 255));
            rc = DW'($urandom_range(0, 255));
            e  = model(int'(ra), int'(rb), int'(rc));
            run_op(ra, rb, rc, e[3*DW-1:2*DW], e[2*DW-1:0], $sformatf("rnd%0d", i));
        end

        // start held high with operands changing every cycle: a run every 6 edges.
        tick();
        n_done = 0;
        for (int k = 0; k < 14; k++) begin
            sif.start = 1'b1;
            sif.a = DW'($urandom_range(0, 255));
            sif.b = DW'($urandom_range(0, 255));
            sif.c = DW'($urandom_range(0, 255));
            if (k % 6 == 0) exp_q.push_back(model(int'(sif.a), int'(sif.b), int'(sif.c)));
            tick();
            score_done();
        end
        sif.start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            score_done();
        end
        check("overlap done count", 32'(n_done), 32'd3);
        check("overlap leftover", 32'(exp_q.size()), 32'd0);

        // Reset while in SUB: asynchronous clear, no done afterwards.
        sif.start = 1'b1;
        sif.a = 8'd9;
        sif.b = 8'd9;
        sif.c = 8'd9;
        tick();
        sif.start = 1'b0;
        tick();
        tick();
        tick();
        check("midrun busy", 32'(sif.busy), 32'd1);
        check("midrun z set", 32'(sif.z), 32'd18);
        Rst = 1'b0;
        #1;
        check("abort z", 32'(sif.z), 32'd0);
        check("abort x", 32'(sif.x), 32'd0);
        check("abort busy", 32'(sif.busy), 32'd0);
        check("abort done", 32'(sif.done), 32'd0);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (sif.done) seen++;
        end
        Rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (sif.done) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);
        run_op(8'd3, 8'd4, 8'd5, 8'd8, 16'd8, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/circuit1_sched_ctrl.md
CIRCUIT1_SCHED_CTRL -- requirements
Module: circuit1_sched_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, operand width; x width is 2*DATAWIDTH.
REQ-002 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a computation; sampled only in IDLE.
REQ-005 SHALL have ports a, b, c  input  DATAWIDTH each  unsigned operands; captured on accepted start.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse; z and x valid.
REQ-008 SHALL have port z  output  DATAWIDTH  z = (d > e) ? d : e.
REQ-009 SHALL have port x  output  2*DATAWIDTH  x = a*c - d.

Function
REQ-010 SHALL compute d = a+b and e = a+c, each truncated to DATAWIDTH (modulo 2^DATAWIDTH).
REQ-011 SHALL compare d and e as unsigned values; equality selects e.
REQ-012 SHALL compute f = a*c at full 2*DATAWIDTH width with no truncation.
REQ-013 SHALL compute x = f - zero-extended d, modulo 2^(2*DATAWIDTH); underflow wraps.
REQ-014 SHALL instantiate exactly one 2*DATAWIDTH adder/subtractor, shared across ADD_D, ADD_E and SUB.
REQ-015 SHALL instantiate exactly one multiplier.
REQ-016 SHALL sequence the work with an FSM whose states are IDLE, ADD_D, ADD_E, CMP_MUL, SUB, DONE.
REQ-017 In IDLE with start=1 at an edge, SHALL register a, b, c and go to ADD_D; with start=0 it SHALL stay in IDLE.
REQ-018 SHALL write d_reg = a+b via the shared adder on the edge leaving ADD_D, then go to ADD_E.
REQ-019 SHALL write e_reg = a+c via the shared adder on the edge leaving ADD_E, then go to CMP_MUL.
REQ-020 On the edge leaving CMP_MUL, SHALL write z from d_reg/e_reg and f_reg from the multiplier, then go to SUB.
REQ-021 SHALL write x = f_reg - d_reg via the shared subtractor on the edge leaving SUB, then go to DONE.
REQ-022 SHALL assert done only in DONE, then return to IDLE unconditionally on the next edge.
REQ-023 Latency: done SHALL be high in the 5th cycle after the edge accepting start; total occupancy is 6 edges.
REQ-024 SHALL ignore start in every state other than IDLE, including DONE; no queuing, captured operands unchanged.
REQ-025 SHALL ignore changes to a, b, c after capture.
REQ-026 SHALL hold z and x from done until overwritten by the next computation; z updates at CMP_MUL and x at SUB of that run.

Reset
REQ-027 Rst=0 SHALL immediately force state IDLE, busy=0, done=0, z=0, x=0 and clear internal operand/d/e/f registers, regardless of clock.
REQ-028 Reset asserted mid-operation SHALL abort the computation with no done pulse.
REQ-029 After Rst deasserts, the first start SHALL be accepted no earlier than the first rising edge with Rst=1.

Verification
REQ-030 Basic: a=3, b=4, c=5, start pulse -> done 5 cycles later; z=8 (d=7, e=8), x=8 (f=15).
REQ-031 Add wrap: a=200, b=100, c=10 -> d=44, e=210, z=210, x=1956.
REQ-032 Sub underflow: a=0, b=5, c=0 -> d=5, e=0, z=5, x=65531.
REQ-033 Max operands: a=255, b=1, c=255 -> d=0, e=254, z=254, x=65025.
REQ-034 Start while busy: start held high for 8 cycles with operands changing -> exactly one done per 6-cycle run, each run uses its captured operands, no start accepted in DONE.
REQ-035 Reset mid-run: Rst low during SUB -> z=0, x=0, busy=0 asynchronously, no done; next start completes normally.
